// File: rtl/out_arb_pkg.sv
// Shared definitions for the output-device arbiter: state encoding,
// requester-count limits and the round-robin index helper.
package out_arb_pkg;

  localparam int MIN_REQ   = 2;
  localparam int MAX_REQ   = 8;
  localparam int GRANT_W   = 3;
  localparam int MAX_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_FIN = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx,
                                                  input int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : GRANT_W'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/out_arbiter_if.sv
// Requester-side and device-side handshake bundle; the arbiter uses the
// master modport, the requesters/device model use the slave modport.
interface out_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_start;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_finish;
  logic [7:0]           out_data;
  logic                 out_start;
  logic                 out_finish;

  modport master (
    input  req_start, req_data, out_finish,
    output req_finish, out_data, out_start
  );

  modport slave (
    output req_start, req_data, out_finish,
    input  req_finish, out_data, out_start
  );
endinterface

// File: rtl/out_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first set request bit
// found searching ptr, ptr+1, ... with wrap modulo N.
module rr_pick
  import out_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               valid,
  output logic [GRANT_W-1:0] idx
);

  logic [2*N-1:0]     req_dbl;
  logic [N-1:0]       hit;
  logic [GRANT_W-1:0] offset;
  logic [GRANT_W:0]   sum;

  // Rotating a doubled copy puts the request at ptr in bit 0.
  assign req_dbl = {req, req} >> ptr;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_hit
      assign hit[gi] = req_dbl[gi];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) offset = GRANT_W'(i);
    end
  end

  assign valid = |hit;
  assign sum   = {1'b0, ptr} + {1'b0, offset};
  assign idx   = (sum >= (GRANT_W+1)'(N)) ? GRANT_W'(sum - (GRANT_W+1)'(N)) : sum[GRANT_W-1:0];

endmodule

// File: rtl/out_arbiter.sv
// Round-robin sharing of one byte-serial output device between NUM_REQ
// requesters, one latched byte per grant, with a finish watchdog.
module out_arbiter
  import out_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  out_arbiter_if.master      bus,
  output logic [GRANT_W-1:0] grant,
  output logic               busy,
  output logic               timeout_err
);

  arb_state_t         state_reg, state_next;
  logic [GRANT_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [GRANT_W-1:0] grant_reg, grant_next;
  logic [7:0]         out_data_reg, out_data_next;
  logic               out_start_reg, out_start_next;
  logic [NUM_REQ-1:0] req_finish_reg, req_finish_next;
  logic [CNT_W-1:0]   wd_cnt_reg, wd_cnt_next;
  logic               timeout_err_reg, timeout_err_next;

  logic               pick_valid;
  logic [GRANT_W-1:0] pick_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               grant_start;
  logic               wd_expired;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (bus.req_start),
    .ptr   (rr_ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign grant_onehot[gi] = (grant_reg == GRANT_W'(gi));
    end
  endgenerate

  assign grant_start = |(bus.req_start & grant_onehot);
  assign wd_expired  = (TIMEOUT != 0) && (wd_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      grant_reg       <= '0;
      out_data_reg    <= '0;
      out_start_reg   <= 1'b0;
      req_finish_reg  <= '0;
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else if (enable) begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      grant_reg       <= grant_next;
      out_data_reg    <= out_data_next;
      out_start_reg   <= out_start_next;
      req_finish_reg  <= req_finish_next;
      wd_cnt_reg      <= wd_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    grant_next       = grant_reg;
    out_data_next    = out_data_reg;
    out_start_next   = out_start_reg;
    req_finish_next  = req_finish_reg;
    wd_cnt_next      = wd_cnt_reg;
    timeout_err_next = timeout_err_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next    = pick_idx;
          out_data_next = bus.req_data[8*pick_idx +: 8];
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        out_start_next = 1'b1;
        wd_cnt_next    = '0;
        state_next     = WAIT_FIN;
      end
      WAIT_FIN: begin
        // A finish arriving on the expiry cycle still counts as success.
        if (bus.out_finish) begin
          out_start_next  = 1'b0;
          req_finish_next = grant_onehot;
          state_next      = RELEASE;
        end else if (wd_expired) begin
          out_start_next   = 1'b0;
          timeout_err_next = 1'b1;
          req_finish_next  = grant_onehot;
          state_next       = RELEASE;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      RELEASE: begin
        if (!grant_start && !bus.out_finish) begin
          req_finish_next = '0;
          rr_ptr_next     = wrap_inc(grant_reg, NUM_REQ);
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.out_data   = out_data_reg;
  assign bus.out_start  = out_start_reg;
  assign bus.req_finish = req_finish_reg;
  assign grant          = grant_reg;
  assign busy           = (state_reg != IDLE);
  assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_out_arbiter.sv
// Directed bench for out_arbiter: single transfer, round-robin order and
// wrap, watchdog abort, reset mid-transfer and enable freeze.
module tb_out_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [2:0] grant;
  logic       busy;
  logic       timeout_err;

  logic       auto_mode = 1'b0;
  logic [3:0] auto_mask = 4'b0000;
  logic [3:0] man_start = 4'b0000;
  logic       inst_fin  = 1'b0;
  logic       man_fin   = 1'b0;
  logic [31:0] data_vec = 32'h4332_2110;

  int total = 0;
  int bad   = 0;
  int got_g [8];
  int got_d [8];
  int gidx  = 0;
  int exp_g [5] = '{0, 1, 2, 3, 0};
  int exp_d [5] = '{32'h10, 32'h21, 32'h32, 32'h43, 32'h10};

  out_arbiter_if #(.NUM_REQ(4)) bus ();

  out_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .CNT_W(11)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Auto requesters drop start on finish and re-raise once it clears.
  always_comb begin
    bus.req_start  = auto_mode ? (auto_mask & ~bus.req_finish) : man_start;
    bus.out_finish = inst_fin ? bus.out_start : man_fin;
    bus.req_data   = data_vec;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic collect(input int n);
    int   cnt;
    logic prev;
    cnt  = 0;
    prev = bus.out_start;
    for (int c = 0; c < 200 && cnt < n; c++) begin
      tick();
      if (bus.out_start && !prev) begin
        got_g[gidx] = int'(grant);
        got_d[gidx] = int'(bus.out_data);
        $display("txn %0d: grant=%0d data=0x%0h", gidx, grant, bus.out_data);
        gidx++;
        cnt++;
      end
      prev = bus.out_start;
    end
    check("collect_count", cnt, n);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && busy; c++) tick();
    check("drain_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset values
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_out_start", bus.out_start, 1'b0);
    check("rst_grant", grant, 3'd0);
    check("rst_req_finish", bus.req_finish, 4'b0000);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    rst = 1'b0;

    // Single requester, device finishes 5 cycles after start
    data_vec[7:0] = 8'h41;
    man_start = 4'b0001;
    tick();
    check("single_issue_start", bus.out_start, 1'b0);
    check("single_busy", busy, 1'b1);
    check("single_data", bus.out_data, 8'h41);
    tick();
    check("single_start_rise", bus.out_start, 1'b1);
    repeat (4) tick();
    check("single_start_hold", bus.out_start, 1'b1);
    check("single_no_finish_yet", bus.req_finish, 4'b0000);
    man_fin = 1'b1;
    tick();
    check("single_req_finish", bus.req_finish, 4'b0001);
    check("single_start_fall", bus.out_start, 1'b0);
    man_fin = 1'b0;
    man_start = 4'b0000;
    tick();
    check("single_release_finish", bus.req_finish, 4'b0000);
    check("single_release_busy", busy, 1'b0);
    $display("txn single: grant=%0d data=0x41 done", grant);
    data_vec[7:0] = 8'h10;

    // All four requesting, instant-finish device
    rst = 1'b1; tick(); rst = 1'b0;
    inst_fin = 1'b1;
    auto_mask = 4'b1111;
    auto_mode = 1'b1;
    gidx = 0;
    collect(5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_grant%0d", i), got_g[i], exp_g[i]);
      check($sformatf("rr_data%0d", i), got_d[i], exp_d[i]);
    end
    auto_mode = 1'b0;
    drain();

    // Grant to 1 moves rr_ptr to 2; then only 0 and 1 request
    auto_mask = 4'b0010;
    auto_mode = 1'b1;
    gidx = 0;
    collect(1);
    auto_mask = 4'b0011;
    collect(3);
    check("wrap_g0", got_g[0], 1);
    check("wrap_g1", got_g[1], 0);
    check("wrap_g2", got_g[2], 1);
    check("wrap_g3", got_g[3], 0);
    auto_mode = 1'b0;
    inst_fin = 1'b0;
    drain();

    // Watchdog abort after 16 cycles of out_start
    rst = 1'b1; tick(); rst = 1'b0;
    man_start = 4'b0100;
    tick(); tick();
    check("wd_start_rise", bus.out_start, 1'b1);
    repeat (15) tick();
    check("wd_start_hold15", bus.out_start, 1'b1);
    check("wd_err_not_yet", timeout_err, 1'b0);
    tick();
    check("wd_start_fall16", bus.out_start, 1'b0);
    check("wd_err_set", timeout_err, 1'b1);
    check("wd_req_finish", bus.req_finish, 4'b0100);
    man_start = 4'b0000;
    tick();
    check("wd_release_busy", busy, 1'b0);
    $display("txn watchdog: grant=2 aborted");
    man_start = 4'b1000;
    tick(); tick();
    check("after_wd_grant", grant, 3'd3);
    check("after_wd_data", bus.out_data, 8'h43);
    man_fin = 1'b1;
    tick();
    check("after_wd_finish", bus.req_finish, 4'b1000);
    man_fin = 1'b0;
    man_start = 4'b0000;
    tick();
    check("after_wd_err_sticky", timeout_err, 1'b1);
    check("after_wd_idle", busy, 1'b0);

    // Reset pulsed in WAIT_FIN
    man_start = 4'b0100;
    tick(); tick();
    check("rstmid_in_wait", bus.out_start, 1'b1);
    man_start = 4'b1010;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_out_start", bus.out_start, 1'b0);
    check("rstmid_req_finish", bus.req_finish, 4'b0000);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_err_clear", timeout_err, 1'b0);
    tick();
    check("rstmid_next_grant", grant, 3'd1);
    check("rstmid_next_data", bus.out_data, 8'h21);
    tick();
    man_fin = 1'b1;
    tick();
    man_fin = 1'b0;
    man_start = 4'b0000;
    tick();
    check("rstmid_done", busy, 1'b0);

    // Finish while idle is ignored
    man_fin = 1'b1;
    tick();
    check("idle_fin_busy", busy, 1'b0);
    check("idle_fin_req_finish", bus.req_finish, 4'b0000);
    man_fin = 1'b0;

    // enable low for 10 cycles during WAIT_FIN freezes the watchdog
    man_start = 4'b0001;
    tick(); tick();
    repeat (3) tick();
    enable = 1'b0;
    repeat (10) tick();
    check("en_hold_start", bus.out_start, 1'b1);
    check("en_hold_busy", busy, 1'b1);
    check("en_hold_req_finish", bus.req_finish, 4'b0000);
    enable = 1'b1;
    repeat (8) tick();
    check("en_no_timeout_start", bus.out_start, 1'b1);
    man_fin = 1'b1;
    tick();
    check("en_finish", bus.req_finish, 4'b0001);
    check("en_start_fall", bus.out_start, 1'b0);
    check("en_no_err", timeout_err, 1'b0);
    man_fin = 1'b0;
    man_start = 4'b0000;
    tick();
    check("en_idle", busy, 1'b0);
    $display("txn enable_freeze: grant=%0d done", grant);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
